scanline_scheduler: RTL and testbench

//  Sequences per-scanline sprite rendering: each line it starts prepare_line, then sprite_drawer, for line sy+1.

---
 rtl/scanline_scheduler.sv | 170 +++++++++++++++++
 tb/tb_scanline_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/scanline_scheduler.sv
// ============================================================================
//  Module      : scanline_scheduler
//  Description : Per-scanline sprite render sequencer (prepare_line, then
//                sprite_drawer, for line sy+1), OAM port steering, line-buffer
//                swap and overrun detection.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scanline_scheduler #(
  parameter int CORDW     = 10,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int H_TOTAL   = 800,
  parameter int V_TOTAL   = 525,
  parameter int TRIGGER_X = 0,
  parameter int OVR_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  output logic             prep_start,
  input  logic             prep_done,
  output logic             draw_start,
  input  logic             draw_done,
  output logic [CORDW-1:0] target_line,
  output logic             oam_sel,
  output logic             swap_buffers,
  output logic             render_abort,
  output logic             busy,
  output logic [OVR_W-1:0] overrun_count
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_prep = 2'd1;
  localparam logic [1:0] c_draw = 2'd2;
  localparam logic [1:0] c_done = 2'd3;

  localparam logic [CORDW-1:0] c_trig_x = CORDW'(TRIGGER_X);
  localparam logic [CORDW-1:0] c_last_x = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] c_last_y = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] c_v_res  = CORDW'(V_RES);

  if ((TRIGGER_X >= H_TOTAL - 1) || (H_RES > H_TOTAL) || (V_RES > V_TOTAL)) begin : g_cfg_check
    $error("scanline_scheduler: inconsistent timing parameters");
  end

  logic [1:0]       state_q,        state_d;
  logic [CORDW-1:0] target_line_q,  target_line_d;
  logic             prep_start_q,   prep_start_d;
  logic             draw_start_q,   draw_start_d;
  logic             swap_q,         swap_d;
  logic             abort_q,        abort_d;
  logic             oam_sel_q,      oam_sel_d;
  logic             busy_q,         busy_d;
  logic             armed_q,        armed_d;
  logic [OVR_W-1:0] overrun_q,      overrun_d;

  logic             w_trigger;
  logic             w_line_end;
  logic [CORDW-1:0] w_nxt;
  logic             w_done_in;
  logic             w_accept;
  logic             w_pulse_cycle;
  logic [OVR_W-1:0] w_overrun_inc;

  assign w_trigger     = (sx == c_trig_x);
  assign w_line_end    = (sx == c_last_x);
  assign w_nxt         = (sy == c_last_y) ? '0 : sy + CORDW'(1);
  assign w_done_in     = (state_q == c_prep) ? prep_done : draw_done;
  assign w_accept      = armed_q && w_done_in;
  // The start-pulse cycle never arms: the sub-block has not yet seen start, so
  // its done level then is stale. Earliest accept is two cycles after start.
  assign w_pulse_cycle = prep_start_q || draw_start_q;
  assign w_overrun_inc = (overrun_q == '1) ? overrun_q : overrun_q + OVR_W'(1);

  always_comb begin
    state_d       = state_q;
    target_line_d = target_line_q;
    prep_start_d  = 1'b0;
    draw_start_d  = 1'b0;
    swap_d        = 1'b0;
    abort_d       = 1'b0;
    armed_d       = armed_q;
    overrun_d     = overrun_q;

    case (state_q)
      c_idle: begin
        armed_d = 1'b0;
        if (w_trigger && (w_nxt < c_v_res)) begin
          target_line_d = w_nxt;
          prep_start_d  = 1'b1;
          state_d       = c_prep;
        end
      end
      c_prep, c_draw: begin
        // Line end wins over a same-cycle done; that render is still late.
        if (w_line_end) begin
          abort_d   = 1'b1;
          overrun_d = w_overrun_inc;
          armed_d   = 1'b0;
          state_d   = c_idle;
        end else if (w_accept) begin
          armed_d = 1'b0;
          if (state_q == c_prep) begin
            draw_start_d = 1'b1;
            state_d      = c_draw;
          end else begin
            state_d = c_done;
          end
        end else if (!w_pulse_cycle && !w_done_in) begin
          armed_d = 1'b1;
        end
      end
      c_done: begin
        armed_d = 1'b0;
        if (w_line_end) begin
          swap_d  = 1'b1;
          state_d = c_idle;
        end
      end
      default: begin
        armed_d = 1'b0;
        state_d = c_idle;
      end
    endcase

    oam_sel_d = (state_d == c_draw) || (state_d == c_done);
    busy_d    = (state_d != c_idle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= c_idle;
      target_line_q <= '0;
      prep_start_q  <= 1'b0;
      draw_start_q  <= 1'b0;
      swap_q        <= 1'b0;
      abort_q       <= 1'b0;
      oam_sel_q     <= 1'b0;
      busy_q        <= 1'b0;
      armed_q       <= 1'b0;
      overrun_q     <= '0;
    end else begin
      state_q       <= state_d;
      target_line_q <= target_line_d;
      prep_start_q  <= prep_start_d;
      draw_start_q  <= draw_start_d;
      swap_q        <= swap_d;
      abort_q       <= abort_d;
      oam_sel_q     <= oam_sel_d;
      busy_q        <= busy_d;
      armed_q       <= armed_d;
      overrun_q     <= overrun_d;
    end
  end

  assign prep_start    = prep_start_q;
  assign draw_start    = draw_start_q;
  assign target_line   = target_line_q;
  assign oam_sel       = oam_sel_q;
  assign swap_buffers  = swap_q;
  assign render_abort  = abort_q;
  assign busy          = busy_q;
  assign overrun_count = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_scanline_scheduler.sv
// ============================================================================
//  Module      : tb_scanline_scheduler
//  Description : Directed self-checking bench for scanline_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scanline_scheduler;

  logic       clk;
  logic       rst;
  logic [9:0] sx, sy;
  logic       prep_done, draw_done;
  logic       prep_start, draw_start, oam_sel, swap_buffers, render_abort, busy;
  logic [9:0] target_line;
  logic [15:0] overrun_count;

  // Small-timing instance so counter saturation is reachable quickly.
  logic [9:0] s_sx, s_sy;
  logic       s_prep_start, s_draw_start, s_oam_sel, s_swap, s_abort, s_busy;
  logic [9:0] s_target_line;
  logic [3:0] s_overrun_count;

  int checks = 0;
  int errors = 0;

  int prep_sx, draw_sx, swap_sx, abort_sx;
  int prep_n, draw_n, swap_n, abort_n;
  logic oam_at_draw;

  scanline_scheduler u_dut (
    .clk           (clk),
    .rst           (rst),
    .sx            (sx),
    .sy            (sy),
    .prep_start    (prep_start),
    .prep_done     (prep_done),
    .draw_start    (draw_start),
    .draw_done     (draw_done),
    .target_line   (target_line),
    .oam_sel       (oam_sel),
    .swap_buffers  (swap_buffers),
    .render_abort  (render_abort),
    .busy          (busy),
    .overrun_count (overrun_count)
  );

  scanline_scheduler #(
    .CORDW(10), .H_RES(4), .V_RES(4), .H_TOTAL(4), .V_TOTAL(5), .TRIGGER_X(0), .OVR_W(4)
  ) u_sat (
    .clk           (clk),
    .rst           (rst),
    .sx            (s_sx),
    .sy            (s_sy),
    .prep_start    (s_prep_start),
    .prep_done     (1'b0),
    .draw_start    (s_draw_start),
    .draw_done     (1'b0),
    .target_line   (s_target_line),
    .oam_sel       (s_oam_sel),
    .swap_buffers  (s_swap),
    .render_abort  (s_abort),
    .busy          (s_busy),
    .overrun_count (s_overrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full 800-pixel line at the current sy. done is high while x < hold
  // and again for the single pixel x == at.
  task automatic run_line(input int p_hold, input int p_at, input int d_hold, input int d_at);
    prep_sx = -1; draw_sx = -1; swap_sx = -1; abort_sx = -1;
    prep_n = 0; draw_n = 0; swap_n = 0; abort_n = 0;
    oam_at_draw = 1'b0;
    for (int x = 0; x < 800; x++) begin
      sx        = 10'(x);
      prep_done = (x < p_hold) || (x == p_at);
      draw_done = (x < d_hold) || (x == d_at);
      tick();
      if (prep_start)   begin prep_n++;  prep_sx  = x; end
      if (draw_start)   begin draw_n++;  draw_sx  = x; oam_at_draw = oam_sel; end
      if (swap_buffers) begin swap_n++;  swap_sx  = x; end
      if (render_abort) begin abort_n++; abort_sx = x; end
    end
    prep_done = 1'b0;
    draw_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sx = 10'd0; sy = 10'd10; prep_done = 1'b1; draw_done = 1'b1;
    s_sx = 10'd0; s_sy = 10'd0;
    repeat (3) tick();
    chk("rst_prep_start", prep_start, 0);
    chk("rst_draw_start", draw_start, 0);
    chk("rst_swap", swap_buffers, 0);
    chk("rst_abort", render_abort, 0);
    chk("rst_target", target_line, 0);
    chk("rst_oam_sel", oam_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun_count, 0);
    chk("rst_sat_busy", s_busy, 0);
    rst = 1'b0; s_sx = 10'd1;

    // Normal line: done pulses at +50 and +400
    sy = 10'd10; run_line(0, 50, 0, 400);
    chk("t1_prep_sx", prep_sx, 0);
    chk("t1_prep_n", prep_n, 1);
    chk("t1_target", target_line, 11);
    chk("t1_draw_sx", draw_sx, 50);
    chk("t1_oam_at_draw", oam_at_draw, 1);
    chk("t1_swap_sx", swap_sx, 799);
    chk("t1_swap_n", swap_n, 1);
    chk("t1_abort_n", abort_n, 0);
    chk("t1_ovr", overrun_count, 0);
    chk("t1_busy_after", busy, 0);
    chk("t1_oam_after", oam_sel, 0);

    // Earliest accept: two cycles after each start pulse
    sy = 10'd11; run_line(0, 3, 0, 6);
    chk("te_target", target_line, 12);
    chk("te_draw_sx", draw_sx, 3);
    chk("te_swap_n", swap_n, 1);
    chk("te_ovr", overrun_count, 0);

    // done one cycle too early is not seen -> overrun
    sy = 10'd12; run_line(0, 2, 0, 6);
    chk("tl_draw_n", draw_n, 0);
    chk("tl_abort_sx", abort_sx, 799);
    chk("tl_swap_n", swap_n, 0);
    chk("tl_ovr", overrun_count, 1);

    // Frame wrap and vertical blank
    sy = 10'd524; run_line(0, 50, 0, 400);
    chk("t2_wrap_target", target_line, 0);
    chk("t2_wrap_prep_n", prep_n, 1);
    chk("t2_wrap_swap_n", swap_n, 1);
    sy = 10'd479; run_line(0, 50, 0, 400);
    chk("t2_vbl_prep_n", prep_n, 0);
    chk("t2_vbl_draw_n", draw_n, 0);
    chk("t2_vbl_swap_n", swap_n, 0);
    chk("t2_vbl_abort_n", abort_n, 0);
    chk("t2_vbl_target_held", target_line, 0);
    sy = 10'd478; run_line(0, 50, 0, 400);
    chk("t2_last_target", target_line, 479);
    chk("t2_last_swap_n", swap_n, 1);
    chk("t2_ovr", overrun_count, 1);

    // Overrun in DRAW, recovery, and line end beating a same-cycle done
    sy = 10'd30; run_line(0, 50, 0, -1);
    chk("t3_abort_sx", abort_sx, 799);
    chk("t3_abort_n", abort_n, 1);
    chk("t3_swap_n", swap_n, 0);
    chk("t3_ovr", overrun_count, 2);
    chk("t3_abort_width", busy, 0);
    sy = 10'd31; run_line(0, 50, 0, 400);
    chk("t3_recover_swap", swap_n, 1);
    chk("t3_recover_abort", abort_n, 0);
    chk("t3_recover_ovr", overrun_count, 2);
    sy = 10'd32; run_line(0, 50, 0, 799);
    chk("t3_prio_abort_n", abort_n, 1);
    chk("t3_prio_swap_n", swap_n, 0);
    chk("t3_prio_ovr", overrun_count, 3);

    // Stale held-high done
    sy = 10'd40; run_line(30, 31, 0, 100);
    chk("t4_prep_stale_draw_sx", draw_sx, 31);
    chk("t4_prep_stale_swap", swap_n, 1);
    sy = 10'd41; run_line(0, 50, 120, -1);
    chk("t4_draw_stale_abort", abort_n, 1);
    chk("t4_draw_stale_swap", swap_n, 0);
    chk("t4_ovr", overrun_count, 4);

    // Reset mid-DRAW
    sy = 10'd20;
    for (int x = 0; x < 60; x++) begin
      sx = 10'(x);
      prep_done = (x == 10);
      tick();
    end
    prep_done = 1'b0;
    chk("t5_pre_oam", oam_sel, 1);
    chk("t5_pre_busy", busy, 1);
    rst = 1'b1; sx = 10'd60;
    tick();
    chk("t5_oam", oam_sel, 0);
    chk("t5_busy", busy, 0);
    chk("t5_pulses", {prep_start, draw_start, swap_buffers, render_abort}, 0);
    chk("t5_ovr", overrun_count, 0);
    chk("t5_target", target_line, 0);
    rst = 1'b0; sx = 10'd61;
    tick();
    chk("t5_idle_after", busy, 0);
    sy = 10'd50; run_line(0, 50, 0, 400);
    chk("t5_next_target", target_line, 51);
    chk("t5_next_swap", swap_n, 1);

    // Saturation on the small instance: 2^4+3 overruns
    s_sy = 10'd0;
    for (int ln = 1; ln <= 19; ln++) begin
      for (int x = 0; x < 4; x++) begin
        s_sx = 10'(x);
        tick();
      end
      if (ln == 1) begin
        chk("t6_first_abort", s_abort, 1);
        chk("t6_first_cnt", s_overrun_count, 1);
      end
      if (ln == 14) chk("t6_cnt14", s_overrun_count, 14);
    end
    chk("t6_saturated", s_overrun_count, 4'hF);
    chk("t6_no_swap", s_swap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
